ss_addsub_window_ctrl: RTL and testbench

- Sequencing controller for a positive-only two-input stochastic add/sub datapath.
- Runs two measurement windows over the same stochastic input streams:
  - positive pass with signs as given;
  - negative pass with all signs inverted (datapath then emits the negative part of the sum).
- In each pass it clears the datapath, enables the stochastic number generators (SNGs) for a programmable window and counts output ones.
- Returns the signed binary result, positive count minus negative count, to the neuron/layer scheduler.

---
 rtl/ss_addsub_window_ctrl_if.sv | 29 ++
 rtl/ss_addsub_window_ctrl.sv | 82 ++++++++
 tb/tb_ss_addsub_window_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ss_addsub_window_ctrl_if.sv
// Bundle between the window controller, its scheduler
// and the stochastic add/sub datapath.
interface ss_addsub_window_ctrl_if #(
  parameter int LOG_LEN = 8,
  parameter int CNT_W   = LOG_LEN + 1
);
  logic               START;
  logic               ABORT;
  logic [LOG_LEN-1:0] WIN_LEN;
  logic               SS_OUT;
  logic               SS_INIT;
  logic               SS_EN;
  logic               SIGN_INV;
  logic               BUSY;
  logic               DONE;
  logic [CNT_W:0]     RESULT;

  modport master (
    output START, ABORT, WIN_LEN, SS_OUT,
    input  SS_INIT, SS_EN, SIGN_INV,
    input  BUSY, DONE, RESULT
  );

  modport slave (
    input  START, ABORT, WIN_LEN, SS_OUT,
    output SS_INIT, SS_EN, SIGN_INV,
    output BUSY, DONE, RESULT
  );
endinterface

// File: rtl/ss_addsub_window_ctrl.sv
// Two-pass window sequencer for a positive-only stochastic
// add/sub datapath; returns pos_count - neg_count.
module ss_addsub_window_ctrl #(
  parameter int LOG_LEN = 8,
  parameter int CNT_W   = LOG_LEN + 1
) (
  input logic CLK,
  input logic INIT_N,
  ss_addsub_window_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, CLR_P, RUN_P, CLR_N, RUN_N, FIN
  } state_e;

  state_e             state_q;
  logic [LOG_LEN-1:0] win_q;
  logic [LOG_LEN-1:0] dcnt_q;
  logic [CNT_W-1:0]   pos_q;
  logic [CNT_W-1:0]   neg_q;
  logic [CNT_W-1:0]   neg_d;
  logic [CNT_W:0]     res_q;

  // includes the final RUN_N sample taken on the FIN-entry edge
  assign neg_d = neg_q + CNT_W'(bus.SS_OUT);

  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      state_q <= IDLE;
      win_q   <= '0;
      dcnt_q  <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
      res_q   <= '0;
    end else if (state_q != IDLE && bus.ABORT) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.START && !bus.ABORT) begin
            state_q <= CLR_P;
            win_q   <= bus.WIN_LEN;
            pos_q   <= '0;
            neg_q   <= '0;
          end
        end
        CLR_P: begin
          dcnt_q  <= win_q;
          state_q <= RUN_P;
        end
        RUN_P: begin
          pos_q  <= pos_q + CNT_W'(bus.SS_OUT);
          dcnt_q <= dcnt_q - LOG_LEN'(1);
          if (dcnt_q == '0) state_q <= CLR_N;
        end
        CLR_N: begin
          dcnt_q  <= win_q;
          state_q <= RUN_N;
        end
        RUN_N: begin
          neg_q  <= neg_d;
          dcnt_q <= dcnt_q - LOG_LEN'(1);
          if (dcnt_q == '0) begin
            state_q <= FIN;
            res_q   <= {1'b0, pos_q} - {1'b0, neg_d};
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.SS_INIT  = (state_q == CLR_P) || (state_q == CLR_N);
  assign bus.SS_EN    = (state_q == RUN_P) || (state_q == RUN_N);
  assign bus.SIGN_INV = (state_q == CLR_N) || (state_q == RUN_N) ||
                        (state_q == FIN);
  assign bus.BUSY     = (state_q != IDLE);
  assign bus.DONE     = (state_q == FIN);
  assign bus.RESULT   = res_q;

endmodule

// File: tb/tb_ss_addsub_window_ctrl.sv
// Randomized scoreboard bench for ss_addsub_window_ctrl.
// Expected results come from window sums over driven bits.
module tb_ss_addsub_window_ctrl;
  localparam int LOG_LEN = 8;
  localparam int CNT_W   = LOG_LEN + 1;

  logic CLK;
  logic INIT_N;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_last = 0;

  typedef struct {
    int res;
    int cyc;
  } exp_t;
  exp_t q[$];

  ss_addsub_window_ctrl_if #(.LOG_LEN(LOG_LEN), .CNT_W(CNT_W)) bus();

  ss_addsub_window_ctrl #(.LOG_LEN(LOG_LEN), .CNT_W(CNT_W)) dut (
    .CLK    (CLK),
    .INIT_N (INIT_N),
    .bus    (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ctl();
    return int'({bus.SS_INIT, bus.SS_EN, bus.SIGN_INV, bus.BUSY, bus.DONE});
  endfunction

  function automatic int res();
    return int'($signed(bus.RESULT));
  endfunction

  // {SS_INIT,SS_EN,SIGN_INV,BUSY,DONE} j cycles after the START edge
  function automatic int exp_ctl(input int j, input int w);
    if (j == 0)          return 5'b10010;
    if (j <= w)          return 5'b01010;
    if (j == w + 1)      return 5'b10110;
    if (j <= 2 * w + 1)  return 5'b01110;
    if (j == 2 * w + 2)  return 5'b00111;
    return 0;
  endfunction

  always @(negedge CLK) begin
    if (INIT_N && bus.DONE) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done actual=DONE expected=none t=%0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", res(), e.res);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  // mode: 0 random, 1 pos=1/neg=0, 2 pos=0/neg=1, 3 all 1, 4 five pos ones
  task automatic run_conv(input int wl, input int mode,
                          input int abort_j, input int rst_j);
    int   w;
    int   expv;
    int   e;
    bit   cut;
    logic bits[0:519];
    w = wl + 1;
    expv = 0;
    cut = (abort_j >= 0 && abort_j < 2 * w + 2) || (rst_j >= 0);
    for (int j = 0; j <= 2 * w + 3; j++) begin
      bit pos;
      bit neg;
      pos = (j >= 1 && j <= w);
      neg = (j >= w + 2 && j <= 2 * w + 1);
      case (mode)
        1:       bits[j] = pos ? 1'b1 : (neg ? 1'b0 : 1'($urandom));
        2:       bits[j] = pos ? 1'b0 : (neg ? 1'b1 : 1'($urandom));
        3:       bits[j] = 1'b1;
        4:       bits[j] = pos && j <= 5;
        default: bits[j] = 1'($urandom);
      endcase
      if (pos) expv += int'(bits[j]);
      if (neg) expv -= int'(bits[j]);
    end
    @(negedge CLK);
    bus.START   = 1'b1;
    bus.ABORT   = 1'b0;
    bus.WIN_LEN = LOG_LEN'(wl);
    bus.SS_OUT  = 1'($urandom);
    @(posedge CLK);
    for (int j = 0; j <= 2 * w + 3; j++) begin
      @(negedge CLK);
      if (j == 0 && !cut) begin
        q.push_back('{expv, cyc + 2 * w + 2});
        exp_last = expv;
      end
      e = (abort_j >= 0 && j > abort_j) ? 0 : exp_ctl(j, w);
      chk("ctl", ctl(), e);
      if (abort_j >= 0 && j > abort_j) break;
      if (j == rst_j) begin
        #2 INIT_N = 1'b0;
        #1;
        chk("rst_ctl", ctl(), 0);
        chk("rst_result", res(), 0);
        exp_last = 0;
        @(negedge CLK);
        INIT_N    = 1'b1;
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        return;
      end
      bus.SS_OUT  = bits[j];
      bus.START   = (j < 2 * w + 3) ? 1'($urandom) : 1'b0;
      bus.WIN_LEN = LOG_LEN'($urandom);
      bus.ABORT   = (j == abort_j);
    end
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    if (abort_j >= 0) chk("result_held", res(), exp_last);
  endtask

  initial begin
    INIT_N      = 1'b0;
    bus.START   = 1'b0;
    bus.ABORT   = 1'b0;
    bus.WIN_LEN = '0;
    bus.SS_OUT  = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("reset_ctl", ctl(), 0);
    end
    INIT_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.SS_OUT = 1'($urandom);
      @(negedge CLK);
      chk("idle_ctl", ctl(), 0);
      chk("idle_result", res(), 0);
    end

    run_conv(7, 1, -1, -1);
    run_conv(255, 2, -1, -1);
    run_conv(0, 3, -1, -1);
    run_conv(7, 4, -1, -1);
    run_conv(7, 0, 8 + 4, -1);
    run_conv(7, 0, -1, -1);
    run_conv(19, 0, -1, 5);
    run_conv(5, 0, -1, -1);
    run_conv(4, 0, 2 * 5 + 2, -1);

    @(negedge CLK);
    bus.START = 1'b1;
    bus.ABORT = 1'b1;
    @(negedge CLK);
    chk("start_abort_idle", ctl(), 0);
    bus.START = 1'b0;
    bus.ABORT = 1'b0;

    for (int i = 0; i < 12; i++) begin
      int wl;
      int ab;
      wl = $urandom_range(0, 40);
      ab = ($urandom % 4 == 0) ? $urandom_range(0, 2 * (wl + 1) + 2) : -1;
      run_conv(wl, 0, ab, -1);
    end

    repeat (3) @(negedge CLK);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
